// File: rtl/game_pkg.sv
// Shared definitions for the switch game: switch count, the game-over LED pattern,
// the auto-player state encoding, LFSR constants and a one-hot check.
package game_pkg;

  localparam int unsigned NUM_SW = 10;
  localparam logic [NUM_SW-1:0] ALL_ONES = '1;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_PROMPT,
    DELAY,
    TOGGLE,
    WAIT_CLEAR,
    HALT
  } state_t;

  // True when exactly one bit of v is set.
  function automatic logic is_onehot(input logic [NUM_SW-1:0] v);
    return (v != '0) && ((v & (v - NUM_SW'(1))) == '0);
  endfunction

endpackage

// File: rtl/auto_player_lfsr16.sv
// Free-running 16-bit Galois LFSR (right shift, taps 16'hB400, seed 16'hACE1).
// Ports: clk, reset (async, active-high), value (current LFSR state).
module lfsr16
  import game_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] value
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value <= LFSR_SEED;
    end else begin
      value <= {1'b0, value[15:1]} ^ (value[0] ? LFSR_TAPS : 16'h0000);
    end
  end

endmodule

// File: rtl/auto_player.sv
// Self-play responder for the switch game: waits for a stable one-hot LED prompt,
// waits a (jittered) reaction delay, then toggles the matching switch. Optional
// deliberate wrong toggles (rotated mask) exercise the game-over path.
// Ports:
//   clk, reset      - clock, asynchronous active-high reset
//   enable          - bot active; low returns the bot to IDLE (sw_out held)
//   led_prompt      - game LED vector (one-hot prompt, all-ones = game over)
//   sw_out          - bot switch vector
//   moves           - toggles issued, saturating at 255
//   mistakes        - deliberate wrong toggles, saturating at 15
//   halted          - set once game over is detected; only reset clears it
module auto_player
  import game_pkg::*;
#(
  parameter int unsigned REACT_CYCLES    = 25000000,
  parameter logic [31:0] JITTER_MASK     = 32'h00FF_FFFF,
  parameter int unsigned ERR_THRESH      = 0,
  parameter int unsigned GAMEOVER_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [NUM_SW-1:0] led_prompt,
  output logic [NUM_SW-1:0] sw_out,
  output logic [7:0]        moves,
  output logic [3:0]        mistakes,
  output logic              halted
);

  localparam int unsigned GO_W = $clog2(GAMEOVER_CYCLES + 1);

  state_t            state, state_nxt;
  logic [15:0]       lfsr;
  logic [NUM_SW-1:0] prev_led;
  logic [NUM_SW-1:0] tgt, tgt_nxt;
  logic [NUM_SW-1:0] sw_nxt;
  logic [NUM_SW-1:0] toggle_mask;
  logic [31:0]       delay, delay_nxt;
  logic [GO_W-1:0]   go_cnt, go_cnt_nxt;
  logic [7:0]        moves_nxt;
  logic [3:0]        mistakes_nxt;
  logic              all_ones;
  logic              go_hit;
  logic              accept;
  logic              fire;
  logic              err_move;

  lfsr16 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .value (lfsr)
  );

  // Game-over detection: this cycle is the GAMEOVER_CYCLES-th consecutive all-ones.
  assign all_ones = (led_prompt == ALL_ONES);
  assign go_hit   = all_ones && ((32'(go_cnt) + 32'd1) >= 32'(GAMEOVER_CYCLES));

  always_comb begin
    go_cnt_nxt = '0;
    if (all_ones) begin
      go_cnt_nxt = (go_cnt == GO_W'(GAMEOVER_CYCLES)) ? go_cnt : go_cnt + GO_W'(1);
    end
  end

  // Prompt is accepted only after it was sampled identical on two consecutive edges.
  assign accept   = (state == WAIT_PROMPT) && enable && !go_hit &&
                    is_onehot(led_prompt) && (led_prompt == prev_led);
  assign fire     = (state == TOGGLE) && enable && !go_hit;
  assign err_move = (ERR_THRESH != 0) && (32'(lfsr[7:0]) < ERR_THRESH);

  // A wrong move toggles the neighbour switch (rotate left, top bit wraps to bit 0).
  assign toggle_mask = err_move ? {tgt[NUM_SW-2:0], tgt[NUM_SW-1]} : tgt;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; HALT is absorbing and outranks enable.
  always_comb begin
    state_nxt = state;
    if (state == HALT || go_hit) begin
      state_nxt = HALT;
    end else if (!enable) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:        state_nxt = WAIT_PROMPT;
        WAIT_PROMPT: if (accept) state_nxt = DELAY;
        DELAY:       if (delay == 32'd0) state_nxt = TOGGLE;
        TOGGLE:      state_nxt = WAIT_CLEAR;
        WAIT_CLEAR:  if (led_prompt != tgt) state_nxt = WAIT_PROMPT;
        default:     state_nxt = IDLE;
      endcase
    end
  end

  // Datapath next values driven by the current state.
  always_comb begin
    tgt_nxt      = tgt;
    delay_nxt    = delay;
    sw_nxt       = sw_out;
    moves_nxt    = moves;
    mistakes_nxt = mistakes;
    if (accept) begin
      tgt_nxt   = led_prompt;
      delay_nxt = 32'(REACT_CYCLES) + ({16'h0000, lfsr} & JITTER_MASK);
    end
    if ((state == DELAY) && enable && !go_hit && (delay != 32'd0)) begin
      delay_nxt = delay - 32'd1;
    end
    if (fire) begin
      sw_nxt = sw_out ^ toggle_mask;
      if (moves != 8'hFF) begin
        moves_nxt = moves + 8'd1;
      end
      if (err_move && (mistakes != 4'hF)) begin
        mistakes_nxt = mistakes + 4'd1;
      end
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_led <= '0;
      tgt      <= '0;
      delay    <= '0;
      go_cnt   <= '0;
      sw_out   <= '0;
      moves    <= '0;
      mistakes <= '0;
      halted   <= 1'b0;
    end else begin
      prev_led <= led_prompt;
      tgt      <= tgt_nxt;
      delay    <= delay_nxt;
      go_cnt   <= go_cnt_nxt;
      sw_out   <= sw_nxt;
      moves    <= moves_nxt;
      mistakes <= mistakes_nxt;
      halted   <= (state_nxt == HALT);
    end
  end

endmodule

// File: tb/tb_auto_player.sv
// Bench for auto_player: two instances (deterministic delay / forced errors with
// jitter) share stimulus; a behavioural model is compared every cycle, and
// hand-computed checks pin the scenario results.
module tb_auto_player;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic [9:0] led_prompt = 10'h000;

  logic [9:0] a_sw, b_sw;
  logic [7:0] a_moves, b_moves;
  logic [3:0] a_mistakes, b_mistakes;
  logic       a_halted, b_halted;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  auto_player #(
    .REACT_CYCLES(4), .JITTER_MASK(32'h0), .ERR_THRESH(0), .GAMEOVER_CYCLES(4)
  ) dut_a (
    .clk(clk), .reset(reset), .enable(enable), .led_prompt(led_prompt),
    .sw_out(a_sw), .moves(a_moves), .mistakes(a_mistakes), .halted(a_halted)
  );

  auto_player #(
    .REACT_CYCLES(3), .JITTER_MASK(32'h7), .ERR_THRESH(255), .GAMEOVER_CYCLES(4)
  ) dut_b (
    .clk(clk), .reset(reset), .enable(enable), .led_prompt(led_prompt),
    .sw_out(b_sw), .moves(b_moves), .mistakes(b_mistakes), .halted(b_halted)
  );

  // Behavioural model of one player.
  // phase: 0 idle, 1 watching for prompt, 2 counting down, 3 about to toggle,
  //        4 waiting for prompt to change, 5 game over
  typedef struct {
    int          phase;
    logic [9:0]  prev;
    logic [9:0]  tgt;
    logic [9:0]  sw;
    int          moves;
    int          mistakes;
    int          ones_run;
    longint      wait_left;
    logic [15:0] lfsr;
  } model_t;

  model_t ma, mb;

  function automatic model_t model_reset();
    model_t m;
    m.phase = 0; m.prev = '0; m.tgt = '0; m.sw = '0;
    m.moves = 0; m.mistakes = 0; m.ones_run = 0; m.wait_left = 0;
    m.lfsr = 16'hACE1;
    return m;
  endfunction

  function automatic model_t model_step(model_t m, logic [9:0] led, logic en,
                                        longint react, logic [31:0] jm, int errth);
    model_t     n;
    int         ones;
    logic [9:0] mask;
    n = m;
    ones = 0;
    for (int i = 0; i < 10; i++) ones += int'(led[i]);
    n.ones_run = (led == 10'h3FF) ? m.ones_run + 1 : 0;
    n.prev = led;
    n.lfsr = (m.lfsr >> 1) ^ (m.lfsr[0] ? 16'hB400 : 16'h0000);
    if (m.phase == 5) return n;
    if (n.ones_run >= 4) begin
      n.phase = 5;
      return n;
    end
    if (!en) begin
      n.phase = 0;
      return n;
    end
    case (m.phase)
      0: n.phase = 1;
      1: if (ones == 1 && led == m.prev) begin
           n.tgt = led;
           n.wait_left = react + longint'({16'h0000, m.lfsr} & jm);
           n.phase = 2;
         end
      2: if (m.wait_left == 0) n.phase = 3;
         else n.wait_left = m.wait_left - 1;
      3: begin
           mask = m.tgt;
           if (errth > 0 && int'(m.lfsr[7:0]) < errth) begin
             mask = {m.tgt[8:0], m.tgt[9]};
             if (n.mistakes < 15) n.mistakes = n.mistakes + 1;
           end
           n.sw = m.sw ^ mask;
           if (n.moves < 255) n.moves = n.moves + 1;
           n.phase = 4;
         end
      4: if (led != m.tgt) n.phase = 1;
      default: n.phase = 0;
    endcase
    return n;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      ma = model_reset();
      mb = model_reset();
    end else begin
      ma = model_step(ma, led_prompt, enable, 4, 32'h0, 0);
      mb = model_step(mb, led_prompt, enable, 3, 32'h7, 255);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (!reset) begin
      check("a.sw_out",   32'(a_sw),       32'(ma.sw));
      check("a.moves",    32'(a_moves),    32'(ma.moves));
      check("a.mistakes", 32'(a_mistakes), 32'(ma.mistakes));
      check("a.halted",   32'(a_halted),   32'(ma.phase == 5));
      check("b.sw_out",   32'(b_sw),       32'(mb.sw));
      check("b.moves",    32'(b_moves),    32'(mb.moves));
      check("b.mistakes", 32'(b_mistakes), 32'(mb.mistakes));
      check("b.halted",   32'(b_halted),   32'(mb.phase == 5));
    end
  end

  task automatic hold(input logic [9:0] v, input int n);
    led_prompt = v;
    repeat (n) @(negedge clk);
  endtask

  logic [9:0] save_a, save_b, one, rv;
  int         save_bm, save_am, r;

  initial begin
    one = 10'h001;
    repeat (3) @(negedge clk);
    check("rst.a.sw", 32'(a_sw), 32'h0);
    check("rst.a.moves", 32'(a_moves), 32'h0);
    check("rst.a.mistakes", 32'(a_mistakes), 32'h0);
    check("rst.a.halted", 32'(a_halted), 32'h0);
    check("rst.b.sw", 32'(b_sw), 32'h0);
    reset = 1'b0;
    @(negedge clk);
    enable = 1'b1;
    repeat (3) @(negedge clk);

    // Latency: new prompt first sampled at edge 0, toggle lands at edge 7.
    led_prompt = 10'h001;
    repeat (7) @(negedge clk);
    check("lat.edge6.sw", 32'(a_sw), 32'h000);
    @(negedge clk);
    check("lat.edge7.sw", 32'(a_sw), 32'h001);
    check("lat.moves", 32'(a_moves), 32'd1);
    repeat (20) @(negedge clk);
    check("held.sw", 32'(a_sw), 32'h001);
    check("held.moves", 32'(a_moves), 32'd1);

    hold(10'h080, 20);
    hold(10'h004, 20);
    check("seq.sw", 32'(a_sw), 32'h085);
    check("seq.moves", 32'(a_moves), 32'd3);
    check("seq.mistakes", 32'(a_mistakes), 32'd0);

    // Forced error on the top switch wraps to bit 0.
    save_b = b_sw; save_bm = int'(b_mistakes);
    hold(10'h200, 20);
    check("err.b.sw", 32'(b_sw), 32'(save_b ^ 10'h001));
    check("err.b.mistakes", 32'(b_mistakes), 32'(save_bm + 1));
    check("err.a.sw", 32'(a_sw), 32'h285);

    // One-cycle glitch is not a prompt.
    hold(10'h000, 5);
    hold(10'h010, 1);
    hold(10'h000, 10);
    check("glitch.sw", 32'(a_sw), 32'h285);
    check("glitch.moves", 32'(a_moves), 32'd4);

    // Short all-ones burst does not end the game.
    hold(10'h3FF, 3);
    hold(10'h001, 20);
    check("burst.sw", 32'(a_sw), 32'h284);
    check("burst.halted", 32'(a_halted), 32'h0);
    check("burst.moves", 32'(a_moves), 32'd5);

    // Enable dropped mid-delay: pending move discarded, one toggle after re-enable.
    hold(10'h002, 3);
    enable = 1'b0;
    repeat (10) @(negedge clk);
    check("en.paused.sw", 32'(a_sw), 32'h284);
    enable = 1'b1;
    repeat (25) @(negedge clk);
    check("en.sw", 32'(a_sw), 32'h286);
    check("en.moves", 32'(a_moves), 32'd6);

    // Randomized play without game over.
    for (int k = 0; k < 150; k++) begin
      r = $urandom_range(0, 9);
      if (r < 6) begin
        hold(one << $urandom_range(0, 9), $urandom_range(1, 25));
      end else if (r < 7) begin
        hold(10'h000, $urandom_range(1, 10));
      end else if (r < 8) begin
        rv = 10'($urandom);
        if (rv == 10'h3FF) rv = 10'h3FE;
        hold(rv, $urandom_range(1, 10));
      end else if (r < 9) begin
        hold(10'h3FF, $urandom_range(1, 3));
        hold(10'h000, 1);
      end else begin
        enable = 1'b0;
        repeat ($urandom_range(1, 8)) @(negedge clk);
        enable = 1'b1;
        @(negedge clk);
      end
    end
    enable = 1'b1;

    // Saturation of moves and mistakes.
    for (int k = 0; k < 270; k++) begin
      hold((k % 2 == 1) ? 10'h002 : 10'h001, 16);
    end
    check("sat.a.moves", 32'(a_moves), 32'd255);
    check("sat.b.moves", 32'(b_moves), 32'd255);
    check("sat.b.mistakes", 32'(b_mistakes), 32'd15);

    // Game over hits on the toggle cycle: toggle suppressed, then frozen.
    hold(10'h000, 3);
    save_a = a_sw;
    hold(10'h004, 4);
    hold(10'h3FF, 4);
    check("go.halted", 32'(a_halted), 32'h1);
    check("go.sw", 32'(a_sw), 32'(save_a));
    save_am = int'(a_moves);
    hold(10'h001, 20);
    check("halt.frozen.sw", 32'(a_sw), 32'(save_a));
    check("halt.frozen.moves", 32'(a_moves), 32'(save_am));
    check("halt.still", 32'(a_halted), 32'h1);
    check("halt.b", 32'(b_halted), 32'h1);

    // Reset leaves HALT.
    reset = 1'b1;
    @(negedge clk);
    check("rst2.a.sw", 32'(a_sw), 32'h0);
    check("rst2.a.moves", 32'(a_moves), 32'h0);
    check("rst2.a.halted", 32'(a_halted), 32'h0);
    check("rst2.b.mistakes", 32'(b_mistakes), 32'h0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/auto_player.md
Name: auto_player

Overview:
- Self-play / demo responder for the switch game; it is the player side of the LED-prompt / switch-response exchange.
- Watches the 10-bit one-hot LED prompt, waits a configurable reaction delay, then toggles the matching bit of its own 10-bit switch vector.
- The top level muxes sw_out onto the game's switch input when demo mode is selected.
- Optional pseudo-random wrong toggles exercise the game-over path.

Parameters:
- NUM_SW, 10, number of switches/LEDs.
- REACT_CYCLES, 25000000, base delay in clk cycles between prompt acceptance and toggle; minimum 1.
- JITTER_MASK, 32'h00FFFFFF, ANDed with LFSR bits and added to REACT_CYCLES; 0 gives a deterministic delay.
- ERR_THRESH, 0, wrong-move chance: ERR_THRESH/256 per move; 0 disables errors.
- GAMEOVER_CYCLES, 4, consecutive all-ones LED cycles that mean game over.

Ports:
- clk  in  1  system clock (50 MHz).
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  bot active; low pauses the bot.
- led_prompt  in  10  game LED vector (one-hot prompt, all-ones = game over).
- sw_out  out  10  bot switch vector.
- moves  out  8  toggles issued since reset, saturating at 255.
- mistakes  out  4  deliberate wrong toggles, saturating at 15.
- halted  out  1  high once game over has been detected.

Behaviour:
- Reset: sw_out=0, moves=0, mistakes=0, halted=0, state=IDLE, LFSR=16'hACE1, all counters cleared.
- Reset is honoured mid-operation from any state.
- Valid prompt: led_prompt has exactly one bit set. Zero, multi-bit and all-ones values are not prompts.
- IDLE: when enable=1, go to WAIT_PROMPT.
- WAIT_PROMPT: a valid prompt must be sampled equal on 2 consecutive edges (stability filter against the game's one-cycle stale LED update). Then:
  - latch the prompt into tgt;
  - load delay = REACT_CYCLES + (lfsr32ext & JITTER_MASK);
  - go to DELAY.
- DELAY: decrement delay each cycle; when it reaches 0, go to TOGGLE.
- TOGGLE, one cycle:
  - If ERR_THRESH > 0 and lfsr[7:0] < ERR_THRESH: toggle mask = tgt rotated left by 1 within NUM_SW (bit 9 wraps to bit 0), and mistakes increments.
  - Otherwise toggle mask = tgt.
  - sw_out ^= mask; moves increments; go to WAIT_CLEAR.
- WAIT_CLEAR: stay until led_prompt != tgt, then go to WAIT_PROMPT. This guarantees one toggle per prompt.
- Latency: with JITTER_MASK=0, sw_out changes at the (REACT_CYCLES+3)th edge after the first edge that samples the new prompt.
- Game-over detector runs in every state:
  - counts consecutive cycles with led_prompt all-ones; any other value clears the count;
  - reaching GAMEOVER_CYCLES forces state HALT and halted=1;
  - the all-ones the game drives during its own reset is shorter than GAMEOVER_CYCLES, so it does not trigger HALT.
- HALT: sw_out frozen, counters frozen. Only reset exits HALT.
- enable falling in any non-HALT state: go to IDLE on the next edge; sw_out is held; a pending delay is discarded. Priority is HALT > enable.
- LFSR advances every clk cycle, including while idle.
- Simultaneous events:
  - a game-over count reaching threshold in the same cycle as TOGGLE: the toggle is suppressed and HALT wins;
  - prompt change during DELAY is ignored; the latched tgt is used.
- Width rules:
  - delay counter is 32-bit;
  - saturating counters never wrap;
  - the rotate uses only NUM_SW bits.

Decomposition:
- Shared package game_pkg:
  - NUM_SW;
  - ALL_ONES constant;
  - state enum {IDLE, WAIT_PROMPT, DELAY, TOGGLE, WAIT_CLEAR, HALT};
  - one-hot check function.
- Sub-module lfsr16: Galois, taps 16'hB400, seed 16'hACE1, free-running, async reset.
- The 32-bit jitter source is the LFSR value zero-extended.

Test Plan:
- REACT_CYCLES=4, JITTER_MASK=0, ERR_THRESH=0. Hold led_prompt=10'h001 from edge 0 -> sw_out goes 0→10'h001 at edge 7; moves=1; no further toggle while the prompt is held.
- led_prompt sequence 10'h001→10'h080→10'h004, each held 20 cycles -> sw_out=10'h085, moves=3, mistakes=0.
- A 1-cycle glitch 10'h010 between stretches of 10'h000 -> no toggle; sw_out unchanged; state stays WAIT_PROMPT.
- ERR_THRESH=255 (forced errors), prompt 10'h200 -> sw_out=10'h001 (wrapped rotate); mistakes=1.
- All-ones for 3 cycles, then a prompt -> normal play. All-ones for 4 cycles during DELAY -> halted=1, toggle suppressed, sw_out frozen; reset -> all outputs 0.
- enable dropped mid-DELAY, raised 10 cycles later with the prompt still present -> a full new delay from re-acceptance; exactly one toggle.
